// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and its prescaler.
package pwm_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Number of counter ticks in one PWM period.
  function automatic int unsigned period_ticks(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable divider: asserts tick once every PRESCALE clock cycles.
module pwm_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  if (PRESCALE <= 1) begin : g_bypass
    // No divider: the clock inputs are intentionally left unused.
    logic unused_inputs;
    assign unused_inputs = CLK ^ RST;
    assign tick = 1'b1;
  end else begin : g_div
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;

    always_comb begin
      pre_cnt_d = (pre_cnt_q == LAST) ? '0 : pre_cnt_q + PW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge CLK) begin
      if (RST) pre_cnt_q <= '0;
      else     pre_cnt_q <= pre_cnt_d;
    end

    assign tick = (pre_cnt_q == LAST);
  end

endmodule

// File: rtl/pwm_generator.sv
// Free-running PWM: period counter, double-buffered duty and registered compare.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DUTY_CYCLE,
  output logic             PWM_OUT,
  output logic             PERIOD_END
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(period_ticks(WIDTH) - 1);

  logic             tick;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;
  logic             pend_q, pend_d;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  // NOTE: every next-state value gets a default first so no path through
  // this block can leave a signal unassigned and infer a latch.
  always_comb begin
    cnt_d  = cnt_q;
    duty_d = duty_q;
    pend_d = 1'b0;
    if (tick) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        duty_d = DUTY_CYCLE;
        pend_d = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
    // Compare against pre-update values: one clock from counter to pin.
    pwm_d = (cnt_q < duty_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      pend_q <= pend_d;
    end
  end

  assign PWM_OUT    = pwm_q;
  assign PERIOD_END = pend_q;

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator at PRESCALE=1 and PRESCALE=4.
module tb_pwm_generator;

  logic       CLK;
  logic       RST, RST4;
  logic [7:0] DUTY_CYCLE, DUTY4;
  logic       PWM_OUT, PERIOD_END;
  logic       PWM4, PEND4;

  int checks   = 0;
  int failures = 0;

  bit ramp_on = 1'b0;
  int ramp_v  = 0;

  pwm_generator #(.WIDTH(8), .PRESCALE(1)) u_dut1 (
    .CLK        (CLK),
    .RST        (RST),
    .DUTY_CYCLE (DUTY_CYCLE),
    .PWM_OUT    (PWM_OUT),
    .PERIOD_END (PERIOD_END)
  );

  pwm_generator #(.WIDTH(8), .PRESCALE(4)) u_dut4 (
    .CLK        (CLK),
    .RST        (RST4),
    .DUTY_CYCLE (DUTY4),
    .PWM_OUT    (PWM4),
    .PERIOD_END (PEND4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Observe one full period (256*ps clocks) starting right after a wrap strobe.
  // Cycle k of the window reflects counter tick (k-1)/ps. Optionally changes
  // the duty input at cycle chg_k and starts a one-step-per-clock ramp at ramp_k.
  task automatic run_period(input bit sel, input int ps, input int exp_high,
                            input int chg_k, input int chg_val, input int ramp_k,
                            input string tag);
    int   high = 0;
    int   bad  = 0;
    int   pends = 0;
    int   last_pend = 0;
    logic p, e;
    for (int k = 1; k <= 256 * ps; k++) begin
      @(negedge CLK);
      p = sel ? PWM4 : PWM_OUT;
      e = sel ? PEND4 : PERIOD_END;
      if (p === 1'b1) high++;
      if (p !== ((((k - 1) / ps) < exp_high) ? 1'b1 : 1'b0)) bad++;
      if (e === 1'b1) pends++;
      if (k == 256 * ps) last_pend = (e === 1'b1) ? 1 : 0;
      if (k == chg_k) begin
        if (sel) DUTY4 = 8'(chg_val);
        else     DUTY_CYCLE = 8'(chg_val);
      end
      if (k == ramp_k) begin
        ramp_on = 1'b1;
        ramp_v  = 0;
      end
      if (ramp_on) begin
        DUTY_CYCLE = 8'(ramp_v);
        if (ramp_v == 99) ramp_on = 1'b0;
        else              ramp_v++;
      end
    end
    check({tag, "_high"},     high,      exp_high * ps);
    check({tag, "_shape"},    bad,       0);
    check({tag, "_pend_cnt"}, pends,     1);
    check({tag, "_pend_pos"}, last_pend, 1);
  endtask

  initial begin
    int high;

    RST        = 1'b1;
    RST4       = 1'b1;
    DUTY_CYCLE = 8'hFF;
    DUTY4      = 8'd0;

    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("reset_pwm",  int'(PWM_OUT),    0);
      check("reset_pend", int'(PERIOD_END), 0);
    end
    RST        = 1'b0;
    DUTY_CYCLE = 8'd64;

    run_period(1'b0, 1, 0,   -1, 0,   -1,  "p0_first");
    run_period(1'b0, 1, 64,  -1, 0,   -1,  "p1_d64");
    run_period(1'b0, 1, 64,  -1, 0,   -1,  "p2_d64");
    run_period(1'b0, 1, 64,  10, 0,   -1,  "p3_d64");
    run_period(1'b0, 1, 0,   10, 255, -1,  "p4_d0");
    run_period(1'b0, 1, 255, 10, 200, -1,  "p5_d255");
    run_period(1'b0, 1, 200, 50, 10,  -1,  "p6_d200_midchg");
    run_period(1'b0, 1, 10,  -1, 0,   200, "p7_d10");
    run_period(1'b0, 1, 55,  -1, 0,   -1,  "p8_ramp_wrap");
    run_period(1'b0, 1, 99,  -1, 0,   -1,  "p9_ramp_hold");

    @(negedge CLK);
    RST4  = 1'b0;
    DUTY4 = 8'd2;
    run_period(1'b1, 4, 0, -1, 0, -1, "ps4_first");
    run_period(1'b1, 4, 2, -1, 0, -1, "ps4_d2");

    // Abort the period while the counter sits at 100.
    high = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge CLK);
      if (PWM4 === 1'b1) high++;
    end
    check("ps4_partial_high", high, 8);
    RST4 = 1'b1;
    @(negedge CLK);
    check("ps4_midrst_pwm",  int'(PWM4),  0);
    check("ps4_midrst_pend", int'(PEND4), 0);
    RST4 = 1'b0;

    run_period(1'b1, 4, 0, -1, 0, -1, "ps4_after_rst");
    run_period(1'b1, 4, 2, -1, 0, -1, "ps4_d2_again");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
